// File: rtl/ula_param_acc.sv
// ula_param_acc: registered WIDTH-bit ALU with an operand-A accumulator and a
// one-entry valid/ready output stage between operand fetch and writeback.
module ula_param_acc #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       X,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             USE_ACC,
    input  logic             ACC_WR,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             ZERO,
    output logic             NEG,
    output logic             OVF,
    output logic [WIDTH-1:0] ACC
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             accept_s;
    logic [WIDTH-1:0] opa_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] res_s;
    logic             cout_s;
    logic             ovf_s;
    logic [WIDTH-1:0] s_r;
    logic [WIDTH-1:0] acc_r;
    logic             cout_r;
    logic             zero_r;
    logic             neg_r;
    logic             ovf_r;

    // The output slot frees up in the same cycle it is drained, so there is no bubble.
    assign IN_READY  = (state_r == ST_EMPTY) || OUT_READY;
    assign accept_s  = IN_VALID && IN_READY;
    assign opa_s     = USE_ACC ? acc_r : A;

    assign OUT_VALID = (state_r == ST_FULL);
    assign S         = s_r;
    assign COUT      = cout_r;
    assign ZERO      = zero_r;
    assign NEG       = neg_r;
    assign OVF       = ovf_r;
    assign ACC       = acc_r;

    // ALU: one extra bit of width carries the ADD carry-out and the SUB borrow.
    always_comb begin
        sum_s  = {1'b0, opa_s} + {1'b0, B} + {{WIDTH{1'b0}}, CIN};
        diff_s = {1'b0, opa_s} - {1'b0, B} - {{WIDTH{1'b0}}, CIN};
        res_s  = {WIDTH{1'b0}};
        cout_s = 1'b0;
        ovf_s  = 1'b0;
        case (X)
            OP_ADD: begin
                res_s  = sum_s[WIDTH-1:0];
                cout_s = sum_s[WIDTH];
                ovf_s  = (opa_s[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != opa_s[WIDTH-1]);
            end
            OP_SUB: begin
                res_s  = diff_s[WIDTH-1:0];
                cout_s = diff_s[WIDTH];
                ovf_s  = (opa_s[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != opa_s[WIDTH-1]);
            end
            OP_AND: res_s = opa_s & B;
            OP_OR:  res_s = opa_s | B;
            OP_NOT: res_s = ~opa_s;
            OP_XOR: res_s = opa_s ^ B;
            OP_SHL: begin
                res_s  = {opa_s[WIDTH-2:0], CIN};
                cout_s = opa_s[WIDTH-1];
            end
            OP_SHR: begin
                res_s  = {CIN, opa_s[WIDTH-1:1]};
                cout_s = opa_s[0];
            end
            default: begin
                res_s  = {WIDTH{1'b0}};
                cout_s = 1'b0;
                ovf_s  = 1'b0;
            end
        endcase
    end

    // Output-slot next state: an accept always (re)fills, a drain without accept empties.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_next_s = ST_FULL;
                end else if (OUT_READY) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: state_next_s = ST_EMPTY;
        endcase
    end

    // Output-slot state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Result/flag register and accumulator; both change only on an accepted request.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s_r    <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
            ovf_r  <= 1'b0;
            acc_r  <= {WIDTH{1'b0}};
        end else begin
            if (accept_s) begin
                s_r    <= res_s;
                cout_r <= cout_s;
                zero_r <= (res_s == {WIDTH{1'b0}});
                neg_r  <= res_s[WIDTH-1];
                ovf_r  <= ovf_s;
            end
            if (accept_s && ACC_WR) begin
                acc_r <= res_s;
            end
        end
    end

endmodule

// File: tb/tb_ula_param_acc.sv
// Self-checking bench for ula_param_acc: directed cases plus random traffic on
// an 8-bit and a 16-bit instance, compared against an arithmetic reference model.
module tb_ula_param_acc;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] st_x [2];
    logic [31:0] st_a [2];
    logic [31:0] st_b [2];
    logic        st_valid [2];
    logic        st_cin [2];
    logic        st_use [2];
    logic        st_accwr [2];
    logic        st_ordy [2];

    logic [7:0]  s8, acc8;
    logic [15:0] s16, acc16;
    logic        o_ir [2];
    logic        o_ov [2];
    logic        o_co [2];
    logic        o_z [2];
    logic        o_n [2];
    logic        o_of [2];
    logic [31:0] o_s [2];
    logic [31:0] o_acc [2];

    assign o_s[0]   = {24'd0, s8};
    assign o_acc[0] = {24'd0, acc8};
    assign o_s[1]   = {16'd0, s16};
    assign o_acc[1] = {16'd0, acc16};

    ula_param_acc #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(st_valid[0]), .IN_READY(o_ir[0]),
        .X(st_x[0][2:0]), .A(st_a[0][7:0]), .B(st_b[0][7:0]), .CIN(st_cin[0]),
        .USE_ACC(st_use[0]), .ACC_WR(st_accwr[0]), .OUT_VALID(o_ov[0]),
        .OUT_READY(st_ordy[0]), .S(s8), .COUT(o_co[0]), .ZERO(o_z[0]),
        .NEG(o_n[0]), .OVF(o_of[0]), .ACC(acc8)
    );

    ula_param_acc #(.WIDTH(16)) dut16 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(st_valid[1]), .IN_READY(o_ir[1]),
        .X(st_x[1][2:0]), .A(st_a[1][15:0]), .B(st_b[1][15:0]), .CIN(st_cin[1]),
        .USE_ACC(st_use[1]), .ACC_WR(st_accwr[1]), .OUT_VALID(o_ov[1]),
        .OUT_READY(st_ordy[1]), .S(s16), .COUT(o_co[1]), .ZERO(o_z[1]),
        .NEG(o_n[1]), .OVF(o_of[1]), .ACC(acc16)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per instance (index 0: WIDTH=8, 1: WIDTH=16)
    longint acc_m [2];
    longint s_m [2];
    logic   ov_m [2];
    logic   co_m [2];
    logic   z_m [2];
    logic   n_m [2];
    logic   of_m [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Operation semantics as integer arithmetic on unsigned/signed values.
    function automatic void ref_op(input int w, input int x, input longint opa, input longint b,
                                   input longint cin, output longint s, output logic cout,
                                   output logic zero, output logic neg, output logic ovf);
        longint m    = longint'(1) << w;
        longint half = m / 2;
        longint sa   = (opa >= half) ? opa - m : opa;
        longint sb   = (b >= half) ? b - m : b;
        longint t;
        cout = 1'b0;
        ovf  = 1'b0;
        s    = 0;
        case (x)
            0: begin
                t = opa + b + cin;
                s = t % m;
                cout = (t >= m);
                t = sa + sb + cin;
                ovf = (t > half - 1) || (t < -half);
            end
            1: begin
                t = opa - b - cin;
                s = (t + m) % m;
                cout = (opa < b + cin);
                t = sa - sb - cin;
                ovf = (t > half - 1) || (t < -half);
            end
            2: s = opa & b;
            3: s = opa | b;
            4: s = (m - 1) - opa;
            5: s = opa ^ b;
            6: begin
                s = (opa * 2 + cin) % m;
                cout = (opa >= half);
            end
            default: begin
                s = opa / 2 + cin * half;
                cout = (opa % 2 == 1);
            end
        endcase
        zero = (s == 0);
        neg  = (s >= half);
    endfunction

    task automatic set_idle();
        for (int j = 0; j < 2; j++) begin
            st_valid[j] = 1'b0; st_x[j] = 32'd0; st_a[j] = 32'd0; st_b[j] = 32'd0;
            st_cin[j] = 1'b0; st_use[j] = 1'b0; st_accwr[j] = 1'b0; st_ordy[j] = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("rst_out_valid%0d", j), {31'd0, o_ov[j]}, 32'd0);
            chk($sformatf("rst_acc%0d", j), o_acc[j], 32'd0);
            chk($sformatf("rst_s%0d", j), o_s[j], 32'd0);
            chk($sformatf("rst_flags%0d", j), {28'd0, o_co[j], o_z[j], o_n[j], o_of[j]}, 32'd0);
            chk($sformatf("rst_in_ready%0d", j), {31'd0, o_ir[j]}, 32'd1);
            acc_m[j] = 0; s_m[j] = 0; ov_m[j] = 1'b0;
            co_m[j] = 1'b0; z_m[j] = 1'b0; n_m[j] = 1'b0; of_m[j] = 1'b0;
        end
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive instance k, check IN_READY before the edge, outputs after it.
    task automatic cycle(input int k, input bit v, input int x, input longint a, input longint b,
                         input bit cin, input bit use_acc, input bit acc_wr, input bit ordy);
        logic   rdy;
        longint opa;
        set_idle();
        st_valid[k] = v; st_x[k] = x; st_a[k] = a[31:0]; st_b[k] = b[31:0];
        st_cin[k] = cin; st_use[k] = use_acc; st_accwr[k] = acc_wr; st_ordy[k] = ordy;
        #1;
        for (int j = 0; j < 2; j++)
            chk($sformatf("in_ready%0d", j), {31'd0, o_ir[j]}, {31'd0, !ov_m[j] || st_ordy[j]});
        @(posedge clk);
        for (int j = 0; j < 2; j++) begin
            rdy = !ov_m[j] || st_ordy[j];
            if (st_valid[j] && rdy) begin
                opa = st_use[j] ? acc_m[j] : longint'(st_a[j]);
                ref_op(j == 0 ? 8 : 16, int'(st_x[j]), opa, longint'(st_b[j]),
                       longint'(st_cin[j]), s_m[j], co_m[j], z_m[j], n_m[j], of_m[j]);
                ov_m[j] = 1'b1;
                if (st_accwr[j]) acc_m[j] = s_m[j];
            end else if (st_ordy[j]) begin
                ov_m[j] = 1'b0;
            end
        end
        #1;
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("out_valid%0d", j), {31'd0, o_ov[j]}, {31'd0, ov_m[j]});
            chk($sformatf("acc%0d", j), o_acc[j], acc_m[j][31:0]);
            if (ov_m[j]) begin
                chk($sformatf("s%0d", j), o_s[j], s_m[j][31:0]);
                chk($sformatf("flags%0d", j), {28'd0, o_co[j], o_z[j], o_n[j], o_of[j]},
                    {28'd0, co_m[j], z_m[j], n_m[j], of_m[j]});
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        set_idle();
        #1;
        do_reset();

        // ADD / SUB corner cases at WIDTH=8
        cycle(0, 1, 0, 'hFF, 'h01, 0, 0, 0, 1);
        chk("add_ff_s", o_s[0], 32'h00);
        chk("add_ff_cz", {30'd0, o_co[0], o_z[0]}, 32'h3);
        chk("add_ff_no", {30'd0, o_n[0], o_of[0]}, 32'h0);
        cycle(0, 1, 0, 'h7F, 'h01, 0, 0, 0, 1);
        chk("add_7f_s", o_s[0], 32'h80);
        chk("add_7f_no", {30'd0, o_n[0], o_of[0]}, 32'h3);
        cycle(0, 1, 1, 'h80, 'h01, 0, 0, 0, 1);
        chk("sub_80_s", o_s[0], 32'h7F);
        chk("sub_80_co", {30'd0, o_co[0], o_of[0]}, 32'h1);
        cycle(0, 1, 1, 'h03, 'h05, 1, 0, 0, 1);
        chk("sub_03_s", o_s[0], 32'hFD);
        chk("sub_03_cn", {30'd0, o_co[0], o_n[0]}, 32'h3);

        // Backpressure
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 'h01, 'h01, 0, 0, 0, 0);
        chk("bp_first_s", o_s[0], 32'h02);
        cycle(0, 1, 3, 'hF0, 'h0F, 0, 0, 0, 0);
        chk("bp_held_s", o_s[0], 32'h02);
        chk("bp_in_ready", {31'd0, o_ir[0]}, 32'd0);
        cycle(0, 1, 3, 'hF0, 'h0F, 0, 0, 0, 1);
        chk("bp_second_s", o_s[0], 32'hFF);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("bp_drained", {31'd0, o_ov[0]}, 32'd0);

        // Accumulator chain from reset
        do_reset();
        cycle(0, 1, 0, 'h00, 'h05, 0, 1, 1, 1);
        chk("acc_chain1", o_s[0], 32'h05);
        cycle(0, 1, 0, 'h00, 'h05, 0, 1, 1, 1);
        chk("acc_chain2", o_s[0], 32'h0A);
        cycle(0, 1, 0, 'h00, 'h05, 0, 1, 1, 1);
        chk("acc_chain3", o_s[0], 32'h0F);
        chk("acc_value", o_acc[0], 32'h0F);

        // Reset while a result is held under backpressure
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_valid", {31'd0, o_ov[0]}, 32'd1);
        do_reset();

        // Shifts and NOT
        cycle(0, 1, 6, 'h81, 'h00, 1, 0, 0, 1);
        chk("shl_s", o_s[0], 32'h03);
        chk("shl_co", {31'd0, o_co[0]}, 32'd1);
        cycle(0, 1, 7, 'h81, 'h00, 0, 0, 0, 1);
        chk("shr_s", o_s[0], 32'h40);
        chk("shr_co", {31'd0, o_co[0]}, 32'd1);
        cycle(0, 1, 4, 'h00, 'h5A, 1, 0, 0, 1);
        chk("not_s", o_s[0], 32'hFF);
        chk("not_co", {31'd0, o_co[0]}, 32'd0);

        // WIDTH=16
        cycle(1, 1, 0, 'hFFFF, 'h0001, 0, 0, 0, 1);
        chk("w16_add_s", o_s[1], 32'h0000);
        chk("w16_add_cz", {30'd0, o_co[1], o_z[1]}, 32'h3);
        cycle(1, 1, 0, 'h7FFF, 'h0001, 0, 0, 0, 1);
        chk("w16_ovf_s", o_s[1], 32'h8000);
        chk("w16_ovf", {31'd0, o_of[1]}, 32'd1);
        cycle(1, 1, 1, 'h8000, 'h0001, 0, 0, 0, 1);
        chk("w16_sub_s", o_s[1], 32'h7FFF);
        cycle(1, 1, 1, 'h0003, 'h0005, 1, 0, 0, 1);
        chk("w16_sub_borrow", o_s[1], 32'hFFFD);
        chk("w16_sub_co", {31'd0, o_co[1]}, 32'd1);

        // Random traffic with random backpressure and accumulator use
        for (int i = 0; i < 600; i++) begin
            int     k;
            longint msk;
            k   = (i < 400) ? 0 : 1;
            msk = (k == 1) ? 64'hFFFF : 64'hFF;
            cycle(k, $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                  longint'($urandom) & msk, longint'($urandom) & msk,
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
